servo_adc_scheduler: RTL and testbench
======================================

SERVO_ADC_SCHEDULER -- requirements
Module: servo_adc_scheduler

Interface
REQ-001 The block SHALL have parameter ADC_WIDTH, default 12, ADC sample width in bits.
REQ-002 The block SHALL have parameter PERIOD_CYCLES, default 1000, clk cycles between scan starts (min 32).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64, max clk cycles from adc_req rise to adc_ack (min 2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high permits new scans to start.
REQ-007 err_clear  input  1  one-cycle pulse; clears sticky error flags.
REQ-008 adc_req  output  1  conversion request to ADC front-end.
REQ-009 adc_ch  output  2  channel index of current request (0..3).
REQ-010 adc_ack  input  1  one-cycle pulse; adc_data valid in the same cycle.
REQ-011 adc_data  input  ADC_WIDTH  conversion result.
REQ-012 i0, i1, i2, i3  output  ADC_WIDTH each  published current samples, channels 0..3.
REQ-013 measurement_trigger  output  1  one-cycle pulse; i0..i3 hold a fresh, coherent set.
REQ-014 busy  output  1  high while a scan is in progress.
REQ-015 overrun  output  1  sticky; a period tick occurred while busy.
REQ-016 adc_timeout  output  1  sticky; a scan was aborted on timeout (only with SERVO_ADC_TIMEOUT_EN).

Function
REQ-017 A free-running period counter SHALL count 0..PERIOD_CYCLES-1 and wrap; tick is the cycle the count equals PERIOD_CYCLES-1.
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT_ACK, GAP, PUBLISH.
REQ-019 IDLE -> REQ on tick with enable high; adc_ch set to 0; otherwise remain IDLE.
REQ-020 REQ: adc_req high, next state WAIT_ACK; adc_req SHALL stay high through WAIT_ACK until the cycle after ack is sampled.
REQ-021 adc_ch SHALL be stable whenever adc_req is high.
REQ-022 WAIT_ACK: on adc_ack, adc_data SHALL be captured into shadow register [adc_ch]; next state GAP if adc_ch<3, else PUBLISH.
REQ-023 GAP: adc_req low for exactly one cycle, adc_ch incremented, next state REQ.
REQ-024 PUBLISH: i0..i3 SHALL load all four shadow registers in the same edge and measurement_trigger SHALL be high for that one cycle; next state IDLE.
REQ-025 Latency: measurement_trigger SHALL assert exactly 1 cycle after the channel-3 ack cycle.
REQ-026 i0..i3 SHALL change only in PUBLISH; partial scans never alter them.
REQ-027 adc_ack while not in WAIT_ACK SHALL be ignored.
REQ-028 Tick while busy SHALL set overrun and SHALL NOT start or restart a scan; the tick is dropped.
REQ-029 enable falling mid-scan SHALL NOT abort; the scan completes and publishes.
REQ-030 busy SHALL be high in every state except IDLE.
REQ-031 err_clear SHALL clear overrun and adc_timeout next edge; a simultaneous set event SHALL win over clear.

Reset
REQ-032 On reset: FSM IDLE, period counter 0, adc_req 0, adc_ch 0, i0..i3 0, shadow registers 0, measurement_trigger 0, busy 0, overrun 0, adc_timeout 0.
REQ-033 Reset asserted mid-scan SHALL drop adc_req on the next edge and discard the partial scan.

Configuration
REQ-034 Macro SERVO_ADC_TIMEOUT_EN defined: a timeout counter SHALL start at adc_req rise; if no ack within TIMEOUT_CYCLES cycles, adc_req drops, adc_timeout sets, no publish, FSM -> IDLE.
REQ-035 Macro SERVO_ADC_TIMEOUT_EN undefined: no timeout counter; WAIT_ACK waits indefinitely; adc_timeout SHALL be tied 0.

Verification (PERIOD_CYCLES=100, TIMEOUT_CYCLES=16, ADC_WIDTH=12)
REQ-036 enable=1, ADC acks 3 cycles after each req with data 0x101,0x202,0x303,0x404 -> i0..i3 = those values, one trigger pulse, i* unchanged before trigger.
REQ-037 Ack delayed 120 cycles per channel -> next tick sets overrun, no second scan; err_clear pulse -> overrun=0.
REQ-038 Timeout macro on, channel 2 never acked -> adc_req low 16 cycles after its rise, adc_timeout=1, i* keep prior scan, no trigger.
REQ-039 Reset asserted during channel-1 WAIT_ACK -> adc_req=0 next edge, all outputs at reset values, first new scan starts 100 cycles later.
REQ-040 enable dropped after channel-0 ack -> scan completes and publishes; no further scan on subsequent ticks while enable=0.
REQ-041 Spurious adc_ack in IDLE with data 0xFFF -> no shadow or output change, no trigger.

Source files
------------

// File: rtl/servo_adc_scheduler.sv
// Periodic four-channel ADC scan scheduler: requests channels 0..3 in turn and publishes a coherent sample set.
// Optional feature: define SERVO_ADC_TIMEOUT_EN to abort a scan whose ack does not arrive within TIMEOUT_CYCLES.
module servo_adc_scheduler #(
    parameter int ADC_WIDTH      = 12,
    parameter int PERIOD_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 err_clear,
    output logic                 adc_req,
    output logic [1:0]           adc_ch,
    input  logic                 adc_ack,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic [ADC_WIDTH-1:0] i0,
    output logic [ADC_WIDTH-1:0] i1,
    output logic [ADC_WIDTH-1:0] i2,
    output logic [ADC_WIDTH-1:0] i3,
    output logic                 measurement_trigger,
    output logic                 busy,
    output logic                 overrun,
    output logic                 adc_timeout,
    output logic [2:0]           dbg_state
);

    // Handshake: adc_req rises with adc_ch stable and holds until the edge that samples a
    // one-cycle adc_ack pulse; adc_data is taken in that same cycle; acks outside WAIT_ACK are ignored.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_GAP      = 3'd3,
        S_PUBLISH  = 3'd4
    } state_t;

    localparam int PCNT_W = $clog2(PERIOD_CYCLES);

    state_t                 state_q;
    logic [PCNT_W-1:0]      pcnt_q, pcnt_d;
    logic                   tick;
    logic                   adc_req_q;
    logic [1:0]             adc_ch_q;
    logic                   trig_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic [ADC_WIDTH-1:0]   shadow_q [4];
    logic [ADC_WIDTH-1:0]   i0_q, i1_q, i2_q, i3_q;

`ifdef SERVO_ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0]        to_cnt_q;
    logic                   timeout_q;
`endif

    always_comb begin
        tick   = (pcnt_q == PCNT_W'(PERIOD_CYCLES - 1));
        pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            adc_req_q <= 1'b0;
            adc_ch_q  <= 2'd0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            i0_q      <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            for (int k = 0; k < 4; k++) begin
                shadow_q[k] <= '0;
            end
`ifdef SERVO_ADC_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            trig_q <= 1'b0;
            // Later set assignments override the clear, so a coincident set event wins.
            if (err_clear) begin
                overrun_q <= 1'b0;
`ifdef SERVO_ADC_TIMEOUT_EN
                timeout_q <= 1'b0;
`endif
            end
            if (tick && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (tick && enable) begin
                        state_q   <= S_REQ;
                        adc_ch_q  <= 2'd0;
                        adc_req_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef SERVO_ADC_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT_ACK;
`ifdef SERVO_ADC_TIMEOUT_EN
                    to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                end
                S_WAIT_ACK: begin
                    if (adc_ack) begin
                        shadow_q[adc_ch_q] <= adc_data;
                        adc_req_q          <= 1'b0;
                        if (adc_ch_q == 2'd3) begin
                            // Channel 3 bypasses its shadow so the set is complete on the trigger cycle.
                            state_q <= S_PUBLISH;
                            i0_q    <= shadow_q[0];
                            i1_q    <= shadow_q[1];
                            i2_q    <= shadow_q[2];
                            i3_q    <= adc_data;
                            trig_q  <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end
`ifdef SERVO_ADC_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        adc_req_q <= 1'b0;
                        adc_ch_q  <= 2'd0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end
                S_GAP: begin
                    state_q   <= S_REQ;
                    adc_ch_q  <= adc_ch_q + 2'd1;
                    adc_req_q <= 1'b1;
`ifdef SERVO_ADC_TIMEOUT_EN
                    to_cnt_q  <= '0;
`endif
                end
                S_PUBLISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    adc_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign adc_req             = adc_req_q;
    assign adc_ch              = adc_ch_q;
    assign i0                  = i0_q;
    assign i1                  = i1_q;
    assign i2                  = i2_q;
    assign i3                  = i3_q;
    assign measurement_trigger = trig_q;
    assign busy                = busy_q;
    assign overrun             = overrun_q;
    assign dbg_state           = state_q;
`ifdef SERVO_ADC_TIMEOUT_EN
    assign adc_timeout         = timeout_q;
`else
    assign adc_timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_servo_adc_scheduler.sv
// Self-checking bench for servo_adc_scheduler: vector-table scans plus hand-written corner sequences.
// The timeout sequence follows SERVO_ADC_TIMEOUT_EN; without it the bench checks that WAIT_ACK never gives up.
module tb_servo_adc_scheduler;
    localparam int W = 12;
    localparam int P = 100;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         reset, enable, err_clear, adc_ack;
    logic [W-1:0] adc_data;
    logic         adc_req;
    logic [1:0]   adc_ch;
    logic [W-1:0] i0, i1, i2, i3;
    logic         measurement_trigger, busy, overrun, adc_timeout;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    servo_adc_scheduler #(.ADC_WIDTH(W), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .enable(enable), .err_clear(err_clear),
        .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .measurement_trigger(measurement_trigger), .busy(busy), .overrun(overrun),
        .adc_timeout(adc_timeout), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [3:0][W-1:0] d;
        int                delay;
    } vec_t;

    int             n_cmp = 0;
    int             n_err = 0;
    int             pc = 0;
    logic [4*W-1:0] exp_q[$];
    logic [4*W-1:0] pub_model = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference period counter and published-value model, both cleared by reset.
    always @(posedge clk) begin
        if (reset) begin
            pc = 0;
            pub_model = '0;
            exp_q.delete();
        end else begin
            pc = (pc == P - 1) ? 0 : pc + 1;
        end
    end

    // Scoreboard: every trigger pops one expected set; between triggers outputs must hold.
    always @(negedge clk) begin
        logic [4*W-1:0] e;
        if (measurement_trigger === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_trigger: got i=0x%0h expected no trigger at %0t", {i3, i2, i1, i0}, $time);
            end else begin
                e = exp_q.pop_front();
                pub_model = e;
                check("publish", {i3, i2, i1, i0}, e);
            end
        end else begin
            check("i_hold", {i3, i2, i1, i0}, pub_model);
        end
    end

    task automatic wait_req(input int budget);
        int k = 0;
        while (adc_req !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", adc_req, 1);
    endtask

    task automatic send_ack(input logic [W-1:0] d);
        adc_ack  = 1'b1;
        adc_data = d;
        @(negedge clk);
        adc_ack  = 1'b0;
        adc_data = '0;
    endtask

    task automatic channel(input int ch, input logic [W-1:0] d, input int delay);
        wait_req(250);
        check($sformatf("ch%0d_idx", ch), adc_ch, ch);
        check("busy_scan", busy, 1);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("req_hold", {adc_req, adc_ch}, {1'b1, 2'(ch)});
        end
        send_ack(d);
        if (ch < 3) begin
            check("gap_low", adc_req, 0);
            @(negedge clk);
            check("gap_next", {adc_req, adc_ch}, {1'b1, 2'(ch + 1)});
        end else begin
            check("trig_latency", measurement_trigger, 1);
            check("req_drop", adc_req, 0);
            @(negedge clk);
            check("idle_after", {busy, measurement_trigger}, 0);
        end
    endtask

    task automatic scan(input logic [3:0][W-1:0] d, input int delay);
        for (int ch = 0; ch < 4; ch++) begin
            if (ch == 3) exp_q.push_back(d);
            channel(ch, d[ch], delay);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, adc_req, 0);
        check({tag, "_ch"}, adc_ch, 0);
        check({tag, "_i"}, {i3, i2, i1, i0}, 0);
        check({tag, "_trig"}, measurement_trigger, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout"}, adc_timeout, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    task automatic wait_tick_cycle();
        int k = 0;
        while (pc != P - 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("tick_found", pc, P - 1);
    endtask

    initial begin
        vec_t              vecs[3];
        logic [3:0][W-1:0] d;
        int                k, rises;

        reset = 1'b1; enable = 1'b0; err_clear = 1'b0; adc_ack = 1'b0; adc_data = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset  = 1'b0;
        enable = 1'b1;

        vecs[0] = '{d: {12'h404, 12'h303, 12'h202, 12'h101}, delay: 3};
        vecs[1] = '{d: {12'h555, 12'hABC, 12'h000, 12'hFFF}, delay: 1};
        vecs[2] = '{d: {W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)),
                        W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095))},
                    delay: $urandom_range(2, 8)};
        for (int v = 0; v < 3; v++) scan(vecs[v].d, vecs[v].delay);

        // Spurious ack while idle must not touch outputs.
        check("idle_state", dbg_state, 0);
        send_ack(12'hFFF);
        check("spurious_trig", measurement_trigger, 0);
        check("spurious_hold", {i3, i2, i1, i0}, vecs[2].d);

        // Ack during the REQ cycle is ignored; the later real ack is published.
        wait_req(250);
        send_ack(12'hBAD);
        check("req_ack_ignored", {adc_req, adc_ch}, {1'b1, 2'd0});
        d = {12'h0DD, 12'h0CC, 12'h0BB, 12'h0AA};
        scan(d, 2);

        // Overrun: tick while channel 0 is stalled; clear; set-wins-over-clear.
        wait_req(250);
        wait_tick_cycle();
        @(negedge clk);
        check("ovr_set", overrun, 1);
        check("no_restart", {adc_req, adc_ch}, {1'b1, 2'd0});
        pulse_clear();
        check("ovr_clear", overrun, 0);
        wait_tick_cycle();
        pulse_clear();
        check("ovr_set_wins", overrun, 1);
        d = {12'h444, 12'h333, 12'h222, 12'h111};
        scan(d, 1);
        check("ovr_sticky", overrun, 1);
        pulse_clear();
        check("ovr_cleared", overrun, 0);

        // Enable dropped mid-scan: scan completes, then no new scans.
        d = {12'h7A4, 12'h7A3, 12'h7A2, 12'h7A1};
        channel(0, d[0], 2);
        enable = 1'b0;
        exp_q.push_back(d);
        for (int ch = 1; ch < 4; ch++) channel(ch, d[ch], 2);
        rises = 0;
        for (int j = 0; j < 250; j++) begin
            @(negedge clk);
            if (adc_req === 1'b1) rises++;
        end
        check("no_scan_disabled", rises, 0);
        check("idle_disabled", busy, 0);
        enable = 1'b1;

        // Reset during channel-1 WAIT_ACK.
        channel(0, 12'h5A5, 2);
        wait_req(10);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("midrst");
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (adc_req !== 1'b1 && k < 300);
        check("restart_delay", k, 100);
        d = {12'h0F4, 12'h0F3, 12'h0F2, 12'h0F1};
        scan(d, 3);

        // Channel 2 never acknowledged.
        d = {12'h9D4, 12'h9D3, 12'h9D2, 12'h9D1};
        channel(0, d[0], 2);
        channel(1, d[1], 2);
        wait_req(10);
        check("ch2_idx_to", adc_ch, 2);
`ifdef SERVO_ADC_TIMEOUT_EN
        k = 0;
        while (adc_req === 1'b1 && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("timeout_req_len", k, T);
        check("timeout_set", adc_timeout, 1);
        check("timeout_idle", {busy, dbg_state}, 0);
        pulse_clear();
        check("timeout_clear", adc_timeout, 0);
`else
        repeat (40) @(negedge clk);
        check("no_timeout_wait", {adc_req, adc_ch}, {1'b1, 2'd2});
        check("timeout_tied", adc_timeout, 0);
        exp_q.push_back(d);
        channel(2, d[2], 1);
        channel(3, d[3], 1);
`endif

        repeat (5) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test expected completion before 1ms");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
